pattern_detector_param: RTL and testbench

PATTERN_DETECTOR_PARAM -- requirements
Module: pattern_detector_param

---
 rtl/pattern_detector_param.sv | 103 ++++++++++
 tb/tb_pattern_detector_param.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pattern_detector_param.sv
// rtl/pattern_detector_param.sv - serial bit-pattern detector with loadable pattern and match counter
//
// Ports:
//   clk          single clock, all state updates on rising edge
//   rst          synchronous active-high reset
//   din          serial data bit
//   din_valid    din is accepted on an edge only when high
//   pat_load     load pat_in into the pattern register (wins over din_valid)
//   pat_in       new pattern, MSB is the first bit in time
//   overlap_en   1 = overlapping matches, 0 = non-overlapping
//   dout         registered match pulse, one cycle after the matching bit
//   match_count  saturating match counter
//
// Optional feature: define MATCH_COUNT_EN to build the match counter;
// without it match_count is tied to 0.
module pattern_detector_param #(
    parameter int                 PAT_LEN     = 5,
    parameter logic [PAT_LEN-1:0] RST_PATTERN = PAT_LEN'(5'b11011),
    parameter int                 CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din,
    input  logic               din_valid,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
    input  logic               overlap_en,
    output logic               dout,
    output logic [CNT_W-1:0]   match_count
);

    localparam int               FW       = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0]    FILL_MAX = FW'(PAT_LEN);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t             state;
    logic [PAT_LEN-1:0] pattern;
    logic [PAT_LEN-1:0] history;
    logic [FW-1:0]      fill;

    logic [PAT_LEN-1:0] hist_next;
    logic [FW-1:0]      fill_next;
    logic               match_hit;

    // Post-shift view of the history; a match is judged on these values.
    always_comb begin
        hist_next = {history[PAT_LEN-2:0], din};
        fill_next = (fill == FILL_MAX) ? FILL_MAX : fill + FW'(1);
        match_hit = din_valid && !pat_load &&
                    (hist_next == pattern) && (fill_next == FILL_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            pattern <= RST_PATTERN;
            history <= '0;
            fill    <= '0;
            dout    <= 1'b0;
        end else if (pat_load) begin
            // The bit offered on a load edge is discarded.
            state   <= EMPTY;
            pattern <= pat_in;
            fill    <= '0;
            dout    <= 1'b0;
        end else if (din_valid) begin
            history <= hist_next;
            dout    <= match_hit;
            if (match_hit && !overlap_en) begin
                // Non-overlapping: restart filling so no bit is reused.
                fill  <= '0;
                state <= EMPTY;
            end else begin
                fill <= fill_next;
                case (state)
                    EMPTY:   state <= (fill_next == FILL_MAX) ? FULL : FILLING;
                    FILLING: state <= (fill_next == FILL_MAX) ? FULL : FILLING;
                    default: state <= FULL;
                endcase
            end
        end else begin
            dout <= 1'b0;
        end
    end

`ifdef MATCH_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            match_count <= '0;
        end else if (match_hit && (match_count != {CNT_W{1'b1}})) begin
            match_count <= match_count + CNT_W'(1);
        end
    end
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_pattern_detector_param.sv
// tb/tb_pattern_detector_param.sv - scoreboard bench for pattern_detector_param
module tb_pattern_detector_param;

    localparam int         PAT_LEN = 5;
    localparam int         CNT_W   = 2;
    localparam logic [4:0] RST_PAT = 5'b11011;

    logic             clk;
    logic             rst;
    logic             din;
    logic             din_valid;
    logic             pat_load;
    logic [4:0]       pat_in;
    logic             overlap_en;
    logic             dout;
    logic [CNT_W-1:0] match_count;

    pattern_detector_param #(
        .PAT_LEN    (PAT_LEN),
        .RST_PATTERN(RST_PAT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .pat_load   (pat_load),
        .pat_in     (pat_in),
        .overlap_en (overlap_en),
        .dout       (dout),
        .match_count(match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard: one expected (dout, count) pair per clock edge.
    int exp_dout_q[$];
    int exp_cnt_q[$];

    // Reference model: pattern plus the list of bits usable for a match.
    logic [4:0] m_pat;
    int         m_bits[$];
    int         m_count;

    function automatic int model_edge(input logic r, input logic v, input logic d,
                                      input logic pl, input logic [4:0] pi,
                                      input logic ov);
        int hit;
        hit = 0;
        if (r) begin
            m_pat = RST_PAT;
            m_bits.delete();
            m_count = 0;
        end else if (pl) begin
            m_pat = pi;
            m_bits.delete();
        end else if (v) begin
            m_bits.push_back(int'(d));
            if (m_bits.size() > PAT_LEN) void'(m_bits.pop_front());
            if (m_bits.size() == PAT_LEN) begin
                hit = 1;
                for (int i = 0; i < PAT_LEN; i++)
                    if (m_bits[i] != int'(m_pat[PAT_LEN-1-i])) hit = 0;
            end
            if (hit == 1) begin
                if (m_count < (1 << CNT_W) - 1) m_count++;
                if (!ov) m_bits.delete();
            end
        end
        return hit;
    endfunction

    task automatic step(input logic r, input logic v, input logic d,
                        input logic pl, input logic [4:0] pi, input logic ov);
        int hit;
        @(negedge clk);
        rst = r; din_valid = v; din = d; pat_load = pl; pat_in = pi; overlap_en = ov;
        hit = model_edge(r, v, d, pl, pi, ov);
        exp_dout_q.push_back(hit);
`ifdef MATCH_COUNT_EN
        exp_cnt_q.push_back(m_count);
`else
        exp_cnt_q.push_back(0);
`endif
        @(posedge clk);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, i[0], 1'b0, 5'b0, 1'b1);
    endtask

    // Sends bits[n-1] first.
    task automatic send_bits(input logic [15:0] bits, input int n, input logic ov);
        for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, bits[i], 1'b0, 5'b0, ov);
    endtask

    // Monitor: compares DUT outputs just after each edge.
    initial begin
        int ed, ec;
        forever begin
            @(posedge clk);
            #1;
            if (exp_dout_q.size() > 0) begin
                ed = exp_dout_q.pop_front();
                ec = exp_cnt_q.pop_front();
                checks++;
                if (int'(dout) != ed) begin
                    errors++;
                    $display("FAIL dout at %0t: got %0d expected %0d", $time, dout, ed);
                end
                checks++;
                if (int'(match_count) != ec) begin
                    errors++;
                    $display("FAIL match_count at %0t: got %0d expected %0d", $time, match_count, ec);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; din = 1'b0; din_valid = 1'b0; pat_load = 1'b0;
        pat_in = 5'b0; overlap_en = 1'b1;
        m_pat = RST_PAT; m_count = 0;

        do_reset();
        do_reset();

        // Basic single match
        send_bits(16'b11011, 5, 1'b1);
        idle(2);

        // Overlapping vs non-overlapping
        do_reset();
        send_bits(16'b11011011, 8, 1'b1);
        idle(2);
        do_reset();
        send_bits(16'b11011011, 8, 1'b0);
        idle(2);

        // Invalid gap with din toggling
        do_reset();
        send_bits(16'b11, 2, 1'b1);
        idle(3);
        send_bits(16'b011, 3, 1'b1);
        idle(2);

        // Pattern load mid-stream; load-cycle din is discarded
        do_reset();
        send_bits(16'b110, 3, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 5'b10101, 1'b1);
        send_bits(16'b10101, 5, 1'b1);
        idle(2);

        // Reset mid-sequence
        do_reset();
        send_bits(16'b1101, 4, 1'b1);
        do_reset();
        send_bits(16'b1, 1, 1'b1);
        idle(1);
        send_bits(16'b11011, 5, 1'b1);
        idle(2);

        // Counter saturation with non-overlapping matches
        do_reset();
        for (int k = 0; k < 5; k++) send_bits(16'b11011, 5, 1'b0);
        idle(2);

        // All-ones pattern, overlapping
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'b11111, 1'b1);
        send_bits(16'hFFFF, 8, 1'b1);
        // All-zeros pattern, overlapping
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'b00000, 1'b1);
        send_bits(16'h0000, 7, 1'b1);
        idle(2);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic r, v, d, pl, ov;
            logic [4:0] pi;
            r  = ($urandom_range(0, 199) == 0);
            pl = ($urandom_range(0, 99) < 2);
            v  = ($urandom_range(0, 9) < 8);
            ov = $urandom_range(0, 1) == 1;
            pi = 5'($urandom);
            if ($urandom_range(0, 3) == 0) pi = ($urandom_range(0, 1) == 1) ? 5'b11111 : 5'b00000;
            // Bias data toward the current pattern so matches are frequent.
            if ($urandom_range(0, 1) == 1 && m_bits.size() < PAT_LEN)
                d = m_pat[PAT_LEN-1-m_bits.size()];
            else
                d = $urandom_range(0, 1) == 1;
            step(r, v, d, pl, pi, ov);
        end
        idle(2);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_dout_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_dout_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
